// File: rtl/seq_tx_fmt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_fmt_pkg                                               |
// | Description : Shared types and constants for the sequencer TX formatter:   |
// |               FSM state encoding, ASCII constants, hex-to-ASCII helper.    |
// |               Optional macro TX_FMT_PREFIX_EN adds a "0x" prefix per word. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seq_tx_fmt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHAR = 2'd1,
        S_GAP  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;
    localparam logic [7:0] c_ASCII_0     = 8'h30;
    localparam logic [7:0] c_ASCII_X     = 8'h78;
    localparam logic [7:0] c_ASCII_A_OFS = 8'h37;   // 'A' - 10

`ifdef TX_FMT_PREFIX_EN
    localparam int c_PREFIX_LEN = 2;
`else
    localparam int c_PREFIX_LEN = 0;
`endif

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return c_ASCII_0 + {4'd0, nib};
        end
        return c_ASCII_A_OFS + {4'd0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_fmt_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_fmt_if                                                |
// | Description : Sequencer-result input and UART-TX output bundle of the      |
// |               TX formatter, plus its status outputs.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface seq_tx_fmt_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) ();
    logic [DATA_W-1:0]             i_data;
    logic                          i_valid;
    logic                          i_tx_busy;
    logic [7:0]                    o_tx_data;
    logic                          o_tx_stb;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt;
    logic                          o_overflow;
    logic                          o_idle;

    // Driver side: sequencer + UART controller
    modport master (
        output i_data, i_valid, i_tx_busy,
        input  o_tx_data, o_tx_stb, o_fifo_cnt, o_overflow, o_idle
    );

    // Formatter side
    modport slave (
        input  i_data, i_valid, i_tx_busy,
        output o_tx_data, o_tx_stb, o_fifo_cnt, o_overflow, o_idle
    );
endinterface
`default_nettype wire

// File: rtl/seq_tx_fmt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_fmt_fifo                                              |
// | Description : Synchronous word FIFO, DATA_W x FIFO_DEPTH. Pointers carry   |
// |               one extra MSB so full and empty are distinguishable.         |
// |               Push while full is accepted only with a same-cycle pop.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_tx_fmt_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_push,
    input  wire logic                          i_pop,
    input  wire logic [DATA_W-1:0]             i_data,
    output logic      [DATA_W-1:0]             o_data,
    output logic                               o_full,
    output logic                               o_empty,
    output logic      [$clog2(FIFO_DEPTH):0]   o_count
);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [c_AW:0]       r_wptr_q, w_wptr_d;
    logic [c_AW:0]       r_rptr_q, w_rptr_d;
    logic [DATA_W-1:0]   r_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   w_mem_d [FIFO_DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty = (r_wptr_q == r_rptr_q);
    assign o_full  = (r_wptr_q[c_AW] != r_rptr_q[c_AW]) &&
                     (r_wptr_q[c_AW-1:0] == r_rptr_q[c_AW-1:0]);
    assign o_count = r_wptr_q - r_rptr_q;
    assign o_data  = r_mem_q[r_rptr_q[c_AW-1:0]];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Next pointer and storage values
    always_comb begin
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        w_mem_d  = r_mem_q;
        if (w_do_push) begin
            w_mem_d[r_wptr_q[c_AW-1:0]] = i_data;
            w_wptr_d = r_wptr_q + 1'b1;
        end
        if (w_do_pop) begin
            w_rptr_d = r_rptr_q + 1'b1;
        end
    end

    // Pointer registers; reset discards the contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
        end
    end

    // Storage, not reset (validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end
endmodule
`default_nettype wire

// File: rtl/seq_tx_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_tx_fmt                                                   |
// | Description : Buffers sequencer result words and renders each as          |
// |               uppercase ASCII hex (MSB nibble first) followed by CR LF,    |
// |               one byte per UART strobe. Define TX_FMT_PREFIX_EN to         |
// |               precede every word with "0x".                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_tx_fmt
    import seq_tx_fmt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_tx_fmt_if.slave bus
);
    localparam int c_NIB    = DATA_W / 4;
    localparam int c_NCHARS = c_PREFIX_LEN + c_NIB + 2;
    localparam int c_IDX_W  = $clog2(c_NCHARS);
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHARS - 1);

    state_t              r_state_q, w_state_d;
    logic [c_IDX_W-1:0]  r_idx_q, w_idx_d, w_idx_next;
    logic [DATA_W-1:0]   r_shift_q, w_shift_d;
    logic [7:0]          r_tx_data_q, w_tx_data_d;
    logic                r_tx_stb_q, w_tx_stb_d;
    logic                r_ovf_q, w_ovf_d;

    logic                w_push, w_pop, w_full, w_empty, w_is_digit;
    logic [DATA_W-1:0]   w_rdata;
    logic [c_AW:0]       w_count;

    // Byte at position idx of a word's character sequence; nib is the
    // nibble currently at the top of the shift register
    function automatic logic [7:0] char_at(input logic [c_IDX_W-1:0] idx,
                                           input logic [3:0] nib);
        int k;
        k = int'(idx);
        if (k < c_PREFIX_LEN) begin
            return (k == 0) ? c_ASCII_0 : c_ASCII_X;
        end
        if (k < c_PREFIX_LEN + c_NIB) begin
            return hex_to_ascii(nib);
        end
        if (k == c_PREFIX_LEN + c_NIB) begin
            return c_ASCII_CR;
        end
        return c_ASCII_LF;
    endfunction

    seq_tx_fmt_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.i_data),
        .o_data  (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A full FIFO still accepts a word if the FSM pops in the same cycle
    assign w_push     = bus.i_valid & (~w_full | w_pop);
    assign w_idx_next = r_idx_q + 1'b1;
    assign w_is_digit = (int'(r_idx_q) >= c_PREFIX_LEN) &&
                        (int'(r_idx_q) <  c_PREFIX_LEN + c_NIB);

    // FSM next state; strobe and byte are prepared one cycle ahead so they
    // are registered and line up with the CHAR state
    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_shift_d   = r_shift_q;
        w_tx_data_d = r_tx_data_q;
        w_tx_stb_d  = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_d   = w_rdata;
                    w_idx_d     = '0;
                    w_tx_data_d = char_at('0, w_rdata[DATA_W-1 -: 4]);
                    w_tx_stb_d  = 1'b1;
                    w_state_d   = S_CHAR;
                end
            end
            S_CHAR: begin
                // Expose the next nibble once the current digit is out
                if (w_is_digit) begin
                    w_shift_d = r_shift_q << 4;
                end
                w_state_d = S_GAP;
            end
            S_GAP: begin
                // Dead cycle lets the UART busy flag rise before it is sampled
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.i_tx_busy) begin
                    if (r_idx_q == c_LAST_IDX) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_idx_d     = w_idx_next;
                        w_tx_data_d = char_at(w_idx_next, r_shift_q[DATA_W-1 -: 4]);
                        w_tx_stb_d  = 1'b1;
                        w_state_d   = S_CHAR;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Sticky overflow: a word arrived while full with no pop to make room
    always_comb begin
        w_ovf_d = r_ovf_q | (bus.i_valid & w_full & ~w_pop);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_idx_q     <= '0;
            r_shift_q   <= '0;
            r_tx_data_q <= '0;
            r_tx_stb_q  <= 1'b0;
            r_ovf_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_idx_q     <= w_idx_d;
            r_shift_q   <= w_shift_d;
            r_tx_data_q <= w_tx_data_d;
            r_tx_stb_q  <= w_tx_stb_d;
            r_ovf_q     <= w_ovf_d;
        end
    end

    assign bus.o_tx_data  = r_tx_data_q;
    assign bus.o_tx_stb   = r_tx_stb_q;
    assign bus.o_fifo_cnt = w_count;
    assign bus.o_overflow = r_ovf_q;
    assign bus.o_idle     = (r_state_q == S_IDLE) && w_empty;
endmodule
`default_nettype wire
